// File: rtl/exec_alu_mc.sv
// exec_alu_mc: multi-cycle execute ALU (add/sub/shift/compare/logic, iterative shift-add MUL).
// Latency: 1 cycle for single-cycle ops, DATA_WIDTH cycles for MUL when MUL_EN=1.
// Backpressure: result held in DONE while out_ready=0; in_ready only in IDLE or DONE with out_ready.
module exec_alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [1:0]            adder_left_opt,
  input  logic [1:0]            adder_right_opt,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_l;
  logic [DATA_WIDTH-1:0] w_r;
  logic [SH_W-1:0]       w_sh;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic                  w_accept;
  logic                  w_is_mul;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_result;
  logic [SH_W-1:0]       r_cnt;

  assign w_sh     = w_r[SH_W-1:0];
  assign w_is_mul = (op == OP_MUL) && MUL_EN;
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign result   = r_result;

  // Left/right operand selection, same encoding as the old adder muxes.
  always_comb begin
    w_l = '0;
    w_r = '0;
    case (adder_left_opt)
      2'd0:    w_l = src1;
      2'd1:    w_l = pc;
      default: w_l = '0;
    endcase
    case (adder_right_opt)
      2'd0:    w_r = imm;
      2'd1:    w_r = DATA_WIDTH'(4);
      2'd2:    w_r = src2;
      default: w_r = '0;
    endcase
  end

  // Single-cycle ALU result; MUL and reserved ops yield 0 here (MUL is iterative when enabled).
  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:  w_alu = w_l + w_r;
      OP_SUB:  w_alu = w_l - w_r;
      OP_SLL:  w_alu = w_l << w_sh;
      OP_SRL:  w_alu = w_l >> w_sh;
      OP_SRA:  w_alu = $unsigned($signed(w_l) >>> w_sh);
      OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_l) < $signed(w_r))};
      OP_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, (w_l < w_r)};
      OP_XOR:  w_alu = w_l ^ w_r;
      OP_OR:   w_alu = w_l | w_r;
      OP_AND:  w_alu = w_l & w_r;
      default: w_alu = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; in_ready depends only on state and out_ready.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        w_accept  = in_valid && out_ready;
        if (w_accept)       w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture result or multiply operands on accept, then one shift-add step per MUL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_acc    <= '0;
        r_mcand  <= w_l;
        r_mplier <= w_r;
        r_cnt    <= SH_W'(DATA_WIDTH - 1);
      end else begin
        r_result <= w_alu;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) r_result <= w_acc_nxt;
      else             r_cnt    <= r_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_alu_mc.sv
// tb_exec_alu_mc: directed stimulus for exec_alu_mc with a reference model and per-cycle checker.
// Latency: checks 1-cycle ops and 32-cycle MUL latency/busy windows.
// Backpressure: exercises out_ready=0 hold and the consume-and-accept cycle.
module tb_exec_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [1:0]  adder_left_opt;
  logic [1:0]  adder_right_opt;
  logic [31:0] src1, src2, imm, pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic        prev_hold;
  logic [31:0] prev_result;

  exec_alu_mc #(.DATA_WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .adder_left_opt(adder_left_opt), .adder_right_opt(adder_right_opt),
    .src1(src1), .src2(src2), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: plain arithmetic on the selected operands.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [1:0] lo, input logic [1:0] ro,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] im, input logic [31:0] p);
    logic [31:0] l, r;
    int          s;
    l = (lo == 2'd0) ? a : (lo == 2'd1) ? p : 32'd0;
    r = (ro == 2'd0) ? im : (ro == 2'd1) ? 32'd4 : (ro == 2'd2) ? b : 32'd0;
    s = r % 32;
    case (o)
      4'd0:    return l + r;
      4'd1:    return l - r;
      4'd2:    return l << s;
      4'd3:    return l >> s;
      4'd4:    return $unsigned($signed(l) >>> s);
      4'd5:    return ($signed(l) < $signed(r)) ? 32'd1 : 32'd0;
      4'd6:    return (l < r) ? 32'd1 : 32'd0;
      4'd7:    return l ^ r;
      4'd8:    return l | r;
      4'd9:    return l & r;
      4'd10:   return l * r;
      default: return 32'd0;
    endcase
  endfunction

  // Track outstanding expected results: push on accept, pop on consume, flush on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready)
        exp_q.push_back(model(op, adder_left_opt, adder_right_opt, src1, src2, imm, pc));
    end
  end

  // Per-cycle checker on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid) begin
        chk("model_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("result_vs_model", result, exp_q[0]);
        chk("busy_while_valid", busy, 1'b0);
      end
      chk("in_ready_rule", in_ready, out_valid ? out_ready : !busy);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", result, prev_result);
      end
      prev_hold   = out_valid && !out_ready;
      prev_result = result;
    end
  end

  task automatic accept_req(input logic [3:0] o, input logic [1:0] lo, input logic [1:0] ro,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] p);
    int k;
    op = o; adder_left_opt = lo; adder_right_opt = ro;
    src1 = a; src2 = b; imm = im; pc = p;
    in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands after acceptance; the unit must not see these.
    src1 = $urandom; src2 = $urandom; imm = $urandom; pc = $urandom;
    op = 4'($urandom);
  endtask

  task automatic wait_result(input string name, input int exp_edges, input int exp_busy,
                             input logic [31:0] exp_res);
    int n, b;
    n = 0; b = 0;
    while (!out_valid && n < 200) begin
      if (busy) b++;
      @(posedge clk); #1; n++;
    end
    chk({name, "_latency"}, n, exp_edges);
    chk({name, "_busy_cycles"}, b, exp_busy);
    chk(name, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0;
    adder_left_opt = '0; adder_right_opt = '0;
    src1 = '0; src2 = '0; imm = '0; pc = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_result", result, 32'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    accept_req(4'd0, 2'd0, 2'd0, 32'h0000_0010, 32'h0, 32'hFFFF_FFF0, 32'h0);
    wait_result("add_wrap", 0, 0, 32'h0000_0000);
    accept_req(4'd0, 2'd1, 2'd1, 32'h0, 32'h0, 32'h0, 32'h8000_0000);
    wait_result("jal_pc4", 0, 0, 32'h8000_0004);
    accept_req(4'd4, 2'd0, 2'd2, 32'h8000_0000, 32'h0000_0021, 32'h0, 32'h0);
    wait_result("sra", 0, 0, 32'hC000_0000);
    accept_req(4'd5, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    wait_result("slt", 0, 0, 32'h1);
    accept_req(4'd6, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    wait_result("sltu", 0, 0, 32'h0);
    accept_req(4'd1, 2'd0, 2'd2, 32'd3, 32'd5, 32'h0, 32'h0);
    wait_result("sub", 0, 0, 32'hFFFF_FFFE);
    accept_req(4'd8, 2'd3, 2'd2, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0);
    wait_result("or_zero_left", 0, 0, 32'h1234_5678);
    accept_req(4'd9, 2'd0, 2'd2, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h0, 32'h0);
    wait_result("and", 0, 0, 32'h00F0_00FF);
    accept_req(4'd2, 2'd0, 2'd0, 32'h0000_0003, 32'h0, 32'hFFFF_FF04, 32'h0);
    wait_result("sll_low_bits", 0, 0, 32'h0000_0030);
    accept_req(4'd13, 2'd0, 2'd2, 32'h1234_5678, 32'h1, 32'h0, 32'h0);
    wait_result("reserved_op", 0, 0, 32'h0);

    accept_req(4'd10, 2'd0, 2'd2, 32'h0001_0003, 32'h0000_0007, 32'h0, 32'h0);
    wait_result("mul_small", 32, 32, 32'h0007_0015);
    accept_req(4'd10, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    wait_result("mul_ones", 32, 32, 32'h0000_0001);

    // Back-to-back single-cycle ops with out_ready held high.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      op = 4'd0; adder_left_opt = 2'd0; adder_right_opt = 2'd0;
      src1 = 32'(i); imm = 32'd10; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_result", result, 32'(i + 10));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    accept_req(4'd0, 2'd0, 2'd0, 32'd1, 32'h0, 32'd2, 32'h0);
    wait_result("bp_add", 0, 0, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", result, 32'd3);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    op = 4'd7; adder_left_opt = 2'd0; adder_right_opt = 2'd2;
    src1 = 32'h0000_00F0; src2 = 32'h0000_00FF;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_xor_valid", out_valid, 1'b1);
    chk("bp_xor_result", result, 32'h0000_000F);
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    accept_req(4'd10, 2'd0, 2'd2, 32'd12345, 32'd678, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    accept_req(4'd0, 2'd0, 2'd0, 32'd2, 32'h0, 32'd2, 32'h0);
    wait_result("post_reset_add", 0, 0, 32'd4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_alu_mc.md
# exec_alu_mc

Multi-cycle, handshaked execute unit for the NPC core. It replaces the single-cycle combinational adder with a parametrised ALU. The ALU keeps the same left/right operand selection and adds subtract, shift, compare and logic operations, plus an optional iterative shift-add multiplier. It sits between decode/register-read and write-back, and uses valid/ready on both sides so the pipeline can stall.

## Interface
- DATA_WIDTH, 32: operand/result width; power of two, ≥8.
- MUL_EN, 1: 1 = MUL op implemented iteratively; 0 = MUL op returns 0 in one cycle.

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept request this cycle
- op  input  4  operation select (encoding below)
- adder_left_opt  input  2  0: src1, 1: pc, 2/3: zero
- adder_right_opt  input  2  0: imm, 1: constant 4, 2: src2, 3: zero
- src1, src2, imm, pc  input  DATA_WIDTH each  operands
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- result  output  DATA_WIDTH  registered result
- busy  output  1  multiply in progress

## Operation
- Operands are selected by the muxes into L and R, which are latched at acceptance; later input changes have no effect.
- op encoding:
  - 0 ADD: L+R
  - 1 SUB: L−R
  - 2 SLL: L<<sh
  - 3 SRL: logical L>>sh
  - 4 SRA: arithmetic L>>sh
  - 5 SLT: signed L<R → 1, else 0
  - 6 SLTU: unsigned L<R → 1, else 0
  - 7 XOR
  - 8 OR
  - 9 AND
  - 10 MUL: low DATA_WIDTH bits of L×R
  - 11–15: result 0, single-cycle
- sh = R[log2(DATA_WIDTH)-1:0]; upper bits of R are ignored for shifts.
- All arithmetic is modulo 2^DATA_WIDTH; no overflow flag.
- FSM states are IDLE, MUL and DONE.
  - IDLE: in_ready=1. On accept:
    - MUL with MUL_EN=1 → MUL; load accumulator=0, multiplicand=L, multiplier=R, count=DATA_WIDTH-1.
    - Any other op → DONE with result registered.
  - MUL: each cycle, if multiplier[0] then accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1. When count==0, go to DONE with result=final accumulator; otherwise count−1.
  - DONE: out_valid=1.
    - out_ready=1 with no new accept → IDLE.
    - out_ready=1 with in_valid=1 → accept the new request (in_ready=1 in DONE only while out_ready=1) and transition exactly as from IDLE.
    - out_ready=0 → hold; result is stable, in_ready=0.
- busy = (state==MUL). in_ready = IDLE | (DONE & out_ready).

## Timing
- Reset values: state IDLE, out_valid 0, result 0, busy 0, in_ready 1, counter and internal registers 0.
- Reset asserted mid-multiply or in DONE discards the operation immediately. No output survives the reset.
- Single-cycle ops: a request accepted at edge E gives out_valid=1 in the cycle after E (latency 1).
- MUL (MUL_EN=1): accepted at edge E, out_valid=1 after edge E+DATA_WIDTH. busy=1 for exactly DATA_WIDTH cycles.
- Back-to-back single-cycle ops with out_ready held 1 give one result per cycle.
- in_ready is combinational from state and out_ready only; it never depends on in_valid.
- out_valid/result never change while out_valid=1 and out_ready=0.

## Test plan
- Reset, then ADD, left=src1=0x0000_0010, right=imm=0xFFFF_FFF0 → out_valid next cycle, result 0x0000_0000.
- JAL-style: left=pc=0x8000_0000, right=4, op ADD → result 0x8000_0004. Then SRA, src1=0x8000_0000, src2=0x0000_0021 (sh=1) → 0xC000_0000.
- SLT vs SLTU with src1=0xFFFF_FFFF, src2=1 → SLT 1, SLTU 0. Then SUB, 3−5 → 0xFFFF_FFFE.
- MUL, src1=0x0001_0003, src2=0x0000_0007: busy=1 for 32 cycles, in_ready=0 throughout, out_valid after 32 edges, result 0x0007_0015. MUL 0xFFFF_FFFF×0xFFFF_FFFF → 0x0000_0001.
- Backpressure: out_ready=0 for 5 cycles after ADD 1+2 → result held at 3, in_ready=0. Raise out_ready with in_valid=1 (XOR 0xF0^0xFF) → 3 consumed and 0x0F valid the next cycle.
- rst_n pulsed low at multiply cycle 10 → out_valid, busy and result go 0 immediately. A following ADD 2+2 returns 4 with latency 1.
